// File: rtl/hh_stdp_if.sv
// hh_stdp_if: tile-level user I/O of the hh_stdp spiking core.
//   ena     : tile enable (the core ignores it and always runs)
//   ui_in   : N1 injected current I1
//   uio_in  : N2 injected current I2
//   uo_out  : N1 membrane potential V1
//   uio_out : {N1 spike, N2 spike, V2[7:2]}
//   uio_oe  : bidirectional pad output enables
// The master modport is the driver of the currents (pad ring / testbench).
// The slave modport is the core.
`timescale 1ns/1ps
interface hh_stdp_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic [DATA_W-1:0] ui_in;
    logic [DATA_W-1:0] uio_in;
    logic [DATA_W-1:0] uo_out;
    logic [DATA_W-1:0] uio_out;
    logic [DATA_W-1:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/hh_stdp.sv
// hh_stdp: two-neuron spiking core. N1 and N2 are integrate/leak/fire units.
// N1 drives N2 through one synapse that is plastic under pair-based STDP.
//
// Ports:
//   clk : system clock; all state updates on its rising edge.
//   rst : asynchronous, active-high reset.
//   bus : hh_stdp_if.slave, carrying ena, ui_in (I1), uio_in (I2),
//         uo_out (V1), uio_out ({spk1, spk2, V2[7:2]}) and uio_oe (all ones).
//
// Build option STDP_LEARN_EN:
//   Defined   - the synapse weight learns; the pre and post traces are built.
//   Undefined - the weight is the constant W_INIT; the neuron datapath is identical.
// Instance "synapse" exposes its register "weight" for hierarchical probing.
`timescale 1ns/1ps

module hh_stdp_synapse #(
    parameter int COEF_W  = 8,
    parameter int W_INIT  = 32,
    parameter int A_PLUS  = 8,
    parameter int A_MINUS = 4,
    parameter int TRACE   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spk_pre,
    input  logic              spk_post,
    output logic [COEF_W-1:0] weight
);
    localparam logic [COEF_W-1:0] W_U = COEF_W'(W_INIT);

`ifdef STDP_LEARN_EN
    localparam int TR_W = $clog2(TRACE + 1);
    localparam logic [TR_W-1:0]   TR_U = TR_W'(TRACE);
    localparam logic [COEF_W-1:0] AP_U = COEF_W'(A_PLUS);
    localparam logic [COEF_W-1:0] AM_U = COEF_W'(A_MINUS);

    logic [TR_W-1:0] pre_trace;
    logic [TR_W-1:0] post_trace;

    function automatic logic [COEF_W-1:0] sat_add(input logic [COEF_W-1:0] w,
                                                 input logic [COEF_W-1:0] d);
        logic [COEF_W:0] s;
        s = {1'b0, w} + {1'b0, d};
        return s[COEF_W] ? '1 : s[COEF_W-1:0];
    endfunction

    function automatic logic [COEF_W-1:0] sat_sub(input logic [COEF_W-1:0] w,
                                                 input logic [COEF_W-1:0] d);
        return (w < d) ? '0 : (w - d);
    endfunction

    // Spikes arriving here are the registered ones, so a trace loaded on a
    // spike is first seen nonzero one cycle later. Coincident spikes leave
    // the weight alone but still reload both traces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight     <= W_U;
            pre_trace  <= '0;
            post_trace <= '0;
        end else begin
            if (spk_pre)
                pre_trace <= TR_U;
            else if (pre_trace != '0)
                pre_trace <= pre_trace - TR_W'(1);

            if (spk_post)
                post_trace <= TR_U;
            else if (post_trace != '0)
                post_trace <= post_trace - TR_W'(1);

            if (spk_post && !spk_pre && (pre_trace != '0))
                weight <= sat_add(weight, AP_U);
            else if (spk_pre && !spk_post && (post_trace != '0))
                weight <= sat_sub(weight, AM_U);
        end
    end
`else
    assign weight = W_U;

    logic unused_syn;
    assign unused_syn = &{1'b0, clk, rst, spk_pre, spk_post};
`endif
endmodule

module hh_stdp #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int V_REST  = 64,
    parameter int V_TH    = 200,
    parameter int V_RESET = 40,
    parameter int REFRAC  = 4,
    parameter int W_INIT  = 32,
    parameter int A_PLUS  = 8,
    parameter int A_MINUS = 4,
    parameter int TRACE   = 16
) (
    input logic       clk,
    input logic       rst,
    hh_stdp_if.slave  bus
);
    // Three guard bits over DATA_W: V + I/2 + weight can exceed 511 before
    // clamping, so a plain 10-bit sum would wrap instead of saturating.
    localparam int SUM_W = DATA_W + 3;
    localparam int REF_W = $clog2(REFRAC + 1);

    localparam logic [DATA_W-1:0]       VREST_U  = DATA_W'(V_REST);
    localparam logic [DATA_W-1:0]       VRESET_U = DATA_W'(V_RESET);
    localparam logic [DATA_W-1:0]       VTH_U    = DATA_W'(V_TH);
    localparam logic [REF_W-1:0]        REF_LOAD = REF_W'(REFRAC);
    localparam logic signed [SUM_W-1:0] VREST_S  = SUM_W'(V_REST);
    localparam logic signed [SUM_W-1:0] VMAX_S   = SUM_W'((1 << DATA_W) - 1);

    // V + (I >> 1) + syn - ((V - V_REST) >>> 3). The arithmetic shift makes
    // the leak pull V toward rest from below as well as from above.
    function automatic logic signed [SUM_W-1:0] integrate(input logic [DATA_W-1:0] v,
                                                         input logic [DATA_W-1:0] i,
                                                         input logic [COEF_W-1:0] syn);
        logic signed [SUM_W-1:0] v_s;
        logic signed [SUM_W-1:0] i_s;
        logic signed [SUM_W-1:0] syn_s;
        logic signed [SUM_W-1:0] leak_s;
        v_s    = signed'(SUM_W'(v));
        i_s    = signed'(SUM_W'(i >> 1));
        syn_s  = signed'(SUM_W'(syn));
        leak_s = (v_s - VREST_S) >>> 3;
        return v_s + i_s + syn_s - leak_s;
    endfunction

    function automatic logic [DATA_W-1:0] sat_u(input logic signed [SUM_W-1:0] x);
        if (x < 0)
            return '0;
        else if (x > VMAX_S)
            return '1;
        else
            return x[DATA_W-1:0];
    endfunction

    // Index 0 is N1, index 1 is N2.
    logic [DATA_W-1:0] v_p0   [2];
    logic              spk_p0 [2];
    logic [REF_W-1:0]  ref_p0 [2];

    logic [DATA_W-1:0] cur  [2];
    logic [COEF_W-1:0] syn  [2];
    logic [DATA_W-1:0] v_cl [2];
    logic              fire [2];
    logic [COEF_W-1:0] weight;

    hh_stdp_synapse #(
        .COEF_W  (COEF_W),
        .W_INIT  (W_INIT),
        .A_PLUS  (A_PLUS),
        .A_MINUS (A_MINUS),
        .TRACE   (TRACE)
    ) synapse (
        .clk      (clk),
        .rst      (rst),
        .spk_pre  (spk_p0[0]),
        .spk_post (spk_p0[1]),
        .weight   (weight)
    );

    // The synaptic kick reaches N2 in the cycle after N1's spike is registered.
    always_comb begin
        cur[0] = bus.ui_in;
        cur[1] = bus.uio_in;
        syn[0] = '0;
        syn[1] = spk_p0[0] ? weight : '0;
        for (int n = 0; n < 2; n++) begin
            v_cl[n] = sat_u(integrate(v_p0[n], cur[n], syn[n]));
            fire[n] = (ref_p0[n] == '0) && (v_cl[n] >= VTH_U);
        end
    end

    // Neuron state: a refractory neuron ignores its input and sits at V_RESET.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                v_p0[n]   <= VREST_U;
                spk_p0[n] <= 1'b0;
                ref_p0[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (ref_p0[n] != '0) begin
                    v_p0[n]   <= VRESET_U;
                    spk_p0[n] <= 1'b0;
                    ref_p0[n] <= ref_p0[n] - REF_W'(1);
                end else if (fire[n]) begin
                    v_p0[n]   <= VRESET_U;
                    spk_p0[n] <= 1'b1;
                    ref_p0[n] <= REF_LOAD;
                end else begin
                    v_p0[n]   <= v_cl[n];
                    spk_p0[n] <= 1'b0;
                end
            end
        end
    end

    assign bus.uo_out  = v_p0[0];
    assign bus.uio_out = {spk_p0[0], spk_p0[1], v_p0[1][DATA_W-1:DATA_W-6]};
    assign bus.uio_oe  = '1;

    logic unused_ena;
    assign unused_ena = &{1'b0, bus.ena};
endmodule

// File: tb/tb_hh_stdp.sv
`timescale 1ns/1ps
module tb_hh_stdp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    hh_stdp_if bus ();

    hh_stdp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef STDP_LEARN_EN
    localparam bit LEARN = 1'b1;
`else
    localparam bit LEARN = 1'b0;
`endif

    typedef struct {
        string      name;
        bit         chk_uo;
        logic [7:0] uo;
        bit         chk_uio;
        logic [7:0] uio;
        bit         chk_w;
        logic [7:0] w;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   n2_spikes = 0;

    // Hand-derived V1 / uio_out after each edge of a 0x80 drive on ui_in from rest.
    localparam logic [7:0] T2_UO  [11] = '{8'd128, 8'd184, 8'd40, 8'd40, 8'd40, 8'd40,
                                           8'd40, 8'd107, 8'd166, 8'd40, 8'd40};
    localparam logic [7:0] T2_UIO [11] = '{8'h10, 8'h10, 8'h90, 8'h18, 8'h17, 8'h16,
                                           8'h15, 8'h15, 8'h14, 8'h94, 8'h1B};
    // Pre-before-post pair, first pair from reset (weight 32).
    localparam logic [7:0] LTP_UO  [5] = '{8'd128, 8'd184, 8'd40, 8'd40, 8'd40};
    localparam logic [7:0] LTP_UIO [5] = '{8'h10, 8'h10, 8'h90, 8'h28, 8'h4A};
    // Post-before-pre pair, first pair from reset.
    localparam logic [7:0] LTD_UO  [6] = '{8'd64, 8'd64, 8'd64, 8'd128, 8'd184, 8'd40};
    localparam logic [7:0] LTD_UIO [6] = '{8'h20, 8'h2E, 8'h4A, 8'h0A, 8'h0A, 8'h8A};

    function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input string n, input bit cu, input logic [7:0] uo,
                                input bit ci, input logic [7:0] uio,
                                input bit cw, input logic [7:0] w);
        exp_t e;
        e.name = n; e.chk_uo = cu; e.uo = uo;
        e.chk_uio = ci; e.uio = uio; e.chk_w = cw; e.w = w;
        return e;
    endfunction

    function automatic exp_t e_none();
        return mk("", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    endfunction

    function automatic exp_t e_out(input string n, input logic [7:0] uo, input logic [7:0] uio);
        return mk(n, 1'b1, uo, 1'b1, uio, 1'b0, 8'd0);
    endfunction

    function automatic exp_t e_w(input string n, input logic [7:0] w);
        return mk(n, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, w);
    endfunction

    // Drive one cycle's inputs at the falling edge and queue what the
    // following rising edge must produce.
    task automatic cyc(input logic r, input logic [7:0] i1, input logic [7:0] i2, input exp_t e);
        @(negedge clk);
        rst        = r;
        bus.ui_in  = i1;
        bus.uio_in = i2;
        sb.push_back(e);
    endtask

    // Monitor: one queue entry per rising edge, sampled 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.uio_out[6] === 1'b1) n2_spikes++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_uo)  chk8({e.name, "_uo"},  bus.uo_out, e.uo);
                if (e.chk_uio) chk8({e.name, "_uio"}, bus.uio_out, e.uio);
                if (e.chk_w)   chk8({e.name, "_w"},   dut.synapse.weight, e.w);
            end
        end
    end

    initial begin
        int s0;
        int wexp;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'd0;
        bus.uio_in = 8'd0;

        // Reset held for 500 ns, then idle at rest.
        for (int k = 0; k < 25; k++) cyc(1'b1, 8'd0, 8'd0, e_out("t1_reset", 8'd64, 8'h10));
        cyc(1'b1, 8'd0, 8'd0, e_w("t1_weight", 8'd32));
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'd0, 8'd0, e_out("t1_idle", 8'd64, 8'h10));
        chk8("t1_oe", bus.uio_oe, 8'hFF);

        // N1 latency, refractory hold, second spike and synaptic kick to N2.
        cyc(1'b1, 8'd0, 8'd0, e_none());
        for (int k = 0; k < 11; k++) cyc(1'b0, 8'h80, 8'd0, e_out($sformatf("t2_e%0d", k + 1), T2_UO[k], T2_UIO[k]));

        // Asynchronous reset in the middle of a spike cycle.
        cyc(1'b1, 8'd0, 8'd0, e_none());
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h80, 8'd0, e_out($sformatf("t6_e%0d", k + 1), T2_UO[k], T2_UIO[k]));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk8("t6_async_uo", bus.uo_out, 8'd64);
        chk8("t6_async_uio", bus.uio_out, 8'h10);
        chk8("t6_async_w", dut.synapse.weight, 8'd32);
        cyc(1'b1, 8'd0, 8'd0, e_out("t6_hold", 8'd64, 8'h10));

        // Ten pre-before-post pairs, 40 cycles each.
        cyc(1'b1, 8'd0, 8'd0, e_none());
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 5; k++)
                cyc(1'b0, (k < 3) ? 8'h80 : 8'h00, (k < 3) ? 8'h00 : 8'h80,
                    (p == 0) ? e_out($sformatf("t3_e%0d", k + 1), LTP_UO[k], LTP_UIO[k]) : e_none());
            for (int k = 0; k < 34; k++) cyc(1'b0, 8'd0, 8'd0, e_none());
            wexp = LEARN ? (32 + 8 * (p + 1)) : 32;
            cyc(1'b0, 8'd0, 8'd0, e_w($sformatf("t3_pair%0d", p), 8'(wexp)));
        end

        // Trained synapse drives N2 on its own.
        s0 = n2_spikes;
        for (int k = 0; k < 100; k++) cyc(1'b0, 8'h80, 8'd0, e_none());
        cyc(1'b0, 8'd0, 8'd0, e_none());
        chk8("t4_n2_fires", ((n2_spikes - s0) > 0) ? 8'd1 : 8'd0, LEARN ? 8'd1 : 8'd0);

        // Untrained synapse: N2 stays below threshold.
        cyc(1'b1, 8'd0, 8'd0, e_none());
        s0 = n2_spikes;
        for (int k = 0; k < 100; k++) cyc(1'b0, 8'h80, 8'd0, e_none());
        cyc(1'b0, 8'd0, 8'd0, e_w("t5_untrained_w", 8'd32));
        chk8("t5_n2_silent", 8'((n2_spikes - s0) > 255 ? 255 : (n2_spikes - s0)), 8'd0);

        // Ten post-before-pre pairs: weight steps down by 4 and sticks at 0.
        cyc(1'b1, 8'd0, 8'd0, e_none());
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 6; k++)
                cyc(1'b0, (k < 3) ? 8'h00 : 8'h80, (k < 3) ? 8'h80 : 8'h00,
                    (p == 0) ? e_out($sformatf("t5_ltd_e%0d", k + 1), LTD_UO[k], LTD_UIO[k]) : e_none());
            for (int k = 0; k < 33; k++) cyc(1'b0, 8'd0, 8'd0, e_none());
            wexp = LEARN ? ((32 - 4 * (p + 1)) < 0 ? 0 : (32 - 4 * (p + 1))) : 32;
            cyc(1'b0, 8'd0, 8'd0, e_w($sformatf("t5_ltd_pair%0d", p), 8'(wexp)));
        end

        cyc(1'b0, 8'd0, 8'd0, e_none());
        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
